// File: rtl/exp_golomb_decoder_if.sv
// Bitstream handshake and decode-result bundle for exp_golomb_decoder.
interface exp_golomb_decoder_if;
    localparam int unsigned K_W    = 3;
    localparam int unsigned DATA_W = 32;

    logic              start;
    logic [K_W-1:0]    k;
    logic              is_ac_level;
    logic              bit_valid;
    logic              bit_in;
    logic              bit_ready;
    logic              output_valid;
    logic [DATA_W-1:0] val;
    logic              is_minus;
    logic [DATA_W-1:0] codeword_length;
    logic              error;

    modport master (
        output start, k, is_ac_level, bit_valid, bit_in,
        input  bit_ready, output_valid, val, is_minus, codeword_length, error
    );

    modport slave (
        input  start, k, is_ac_level, bit_valid, bit_in,
        output bit_ready, output_valid, val, is_minus, codeword_length, error
    );
endinterface

// File: rtl/exp_golomb_decoder.sv
// Serial k-th order Exp-Golomb decoder, one bit per accepted handshake.
// Define EXP_GOLOMB_DEC_SIGN_EN to read a trailing sign bit for AC-level codewords.
module exp_golomb_decoder #(
    parameter int unsigned MAX_PREFIX = 24
) (
    input logic                 clk,
    input logic                 reset,
    exp_golomb_decoder_if.slave dec
);
    localparam int unsigned K_W    = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned Q_W    = $clog2(MAX_PREFIX + 1);
    localparam int unsigned REM_W  = 6;

`ifdef EXP_GOLOMB_DEC_SIGN_EN
    typedef enum logic [2:0] {IDLE, PREFIX, SUFFIX, SIGN, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, PREFIX, SUFFIX, DONE} state_t;
`endif

    state_t            state, state_next;
    logic [K_W-1:0]    k_q, k_next;
    logic [Q_W-1:0]    q_cnt, q_next;
    logic [DATA_W-1:0] acc, acc_next;
    logic [REM_W-1:0]  remaining, rem_next;
    logic              accept_c;
    logic              err_c;
    state_t            tail_state_c;
`ifdef EXP_GOLOMB_DEC_SIGN_EN
    logic              sign_en_q, sign_en_next;
    logic              sign_q, sign_next;
`endif

    // Where the codeword goes once the last magnitude bit is in
`ifdef EXP_GOLOMB_DEC_SIGN_EN
    assign tail_state_c = sign_en_q ? SIGN : DONE;
    assign accept_c     = dec.bit_valid &&
                          (state == PREFIX || state == SUFFIX || state == SIGN);
`else
    assign tail_state_c = DONE;
    assign accept_c     = dec.bit_valid && (state == PREFIX || state == SUFFIX);
`endif

    always_comb begin
        state_next = state;
        k_next     = k_q;
        q_next     = q_cnt;
        acc_next   = acc;
        rem_next   = remaining;
        err_c      = 1'b0;
`ifdef EXP_GOLOMB_DEC_SIGN_EN
        sign_en_next = sign_en_q;
        sign_next    = sign_q;
`endif
        unique case (state)
            IDLE: begin
                if (dec.start) begin
                    k_next     = dec.k;
                    q_next     = '0;
                    acc_next   = '0;
                    state_next = PREFIX;
`ifdef EXP_GOLOMB_DEC_SIGN_EN
                    sign_en_next = dec.is_ac_level;
                    sign_next    = 1'b0;
`endif
                end
            end
            PREFIX: begin
                if (accept_c) begin
                    if (!dec.bit_in) begin
                        if (q_cnt == Q_W'(MAX_PREFIX)) begin
                            err_c      = 1'b1;
                            state_next = IDLE;
                        end else begin
                            q_next = q_cnt + Q_W'(1);
                        end
                    end else begin
                        acc_next   = DATA_W'(1);
                        rem_next   = REM_W'(q_cnt) + REM_W'(k_q);
                        state_next = (rem_next != '0) ? SUFFIX : tail_state_c;
                    end
                end
            end
            SUFFIX: begin
                if (accept_c) begin
                    acc_next = {acc[DATA_W-2:0], dec.bit_in};
                    rem_next = remaining - REM_W'(1);
                    if (remaining == REM_W'(1)) state_next = tail_state_c;
                end
            end
`ifdef EXP_GOLOMB_DEC_SIGN_EN
            SIGN: begin
                if (accept_c) begin
                    sign_next  = dec.bit_in;
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are registered on entry to DONE so output_valid follows the last bit by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            k_q                 <= '0;
            q_cnt               <= '0;
            acc                 <= '0;
            remaining           <= '0;
            dec.bit_ready       <= 1'b0;
            dec.output_valid    <= 1'b0;
            dec.error           <= 1'b0;
            dec.val             <= '0;
            dec.is_minus        <= 1'b0;
            dec.codeword_length <= '0;
`ifdef EXP_GOLOMB_DEC_SIGN_EN
            sign_en_q           <= 1'b0;
            sign_q              <= 1'b0;
`endif
        end else begin
            state            <= state_next;
            k_q              <= k_next;
            q_cnt            <= q_next;
            acc              <= acc_next;
            remaining        <= rem_next;
            dec.bit_ready    <= (state_next == PREFIX) || (state_next == SUFFIX)
`ifdef EXP_GOLOMB_DEC_SIGN_EN
                                || (state_next == SIGN)
`endif
                                ;
            dec.output_valid <= (state_next == DONE);
            dec.error        <= err_c;
`ifdef EXP_GOLOMB_DEC_SIGN_EN
            sign_en_q        <= sign_en_next;
            sign_q           <= sign_next;
`endif
            if (state_next == DONE) begin
                dec.val <= acc_next - (DATA_W'(1) << k_q);
`ifdef EXP_GOLOMB_DEC_SIGN_EN
                dec.is_minus        <= sign_next;
                dec.codeword_length <= (DATA_W'(q_cnt) << 1) + DATA_W'(k_q) + DATA_W'(1)
                                       + DATA_W'(sign_en_q);
`else
                dec.is_minus        <= 1'b0;
                dec.codeword_length <= (DATA_W'(q_cnt) << 1) + DATA_W'(k_q) + DATA_W'(1);
`endif
            end
        end
    end
endmodule

// File: tb/tb_exp_golomb_decoder.sv
// Directed scoreboard bench for exp_golomb_decoder; follows EXP_GOLOMB_DEC_SIGN_EN when defined.
module tb_exp_golomb_decoder;
    typedef struct {
        bit          err;
        logic [31:0] val;
        logic        minus;
        logic [31:0] len;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;
    exp_t sb[$];

    exp_golomb_decoder_if dif ();

    exp_golomb_decoder #(.MAX_PREFIX(24)) dut (
        .clk   (clk),
        .reset (reset),
        .dec   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    // Monitor: every output_valid or error pulse must match the oldest expectation
    always @(negedge clk) begin
        if (reset === 1'b0 && (dif.output_valid === 1'b1 || dif.error === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {30'd0, dif.error, dif.output_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("error_flag", 32'(dif.error), 32'(e.err));
                chk("valid_flag", 32'(dif.output_valid), 32'(!e.err));
                if (!e.err) begin
                    chk("val", dif.val, e.val);
                    chk("is_minus", 32'(dif.is_minus), 32'(e.minus));
                    chk("codeword_length", dif.codeword_length, e.len);
                end
            end
        end
    end

    // Caller is just after a posedge; returns just after the posedge where the DUT is back in IDLE
    task automatic decode(input int kk, input bit ac, input logic [63:0] bits, input int n,
                          input bit stall, input bit exp_err, input logic [31:0] exp_val,
                          input logic exp_minus, input logic [31:0] exp_len);
        exp_t e;
        e.err = exp_err; e.val = exp_val; e.minus = exp_minus; e.len = exp_len;
        sb.push_back(e);
        dif.start = 1'b1; dif.k = 3'(kk); dif.is_ac_level = ac;
        @(posedge clk); #1;
        dif.start = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            dif.bit_valid = 1'b1;
            dif.bit_in    = bits[i];
            @(posedge clk); #1;
            dif.bit_valid = 1'b0;
            if (stall && i > 0) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        if (exp_err) begin
            chk("error_latency", 32'(dif.error), 32'd1);
            chk("ready_after_error", 32'(dif.bit_ready), 32'd0);
        end else begin
            chk("valid_latency", 32'(dif.output_valid), 32'd1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        reset = 1'b1;
        dif.start = 1'b0; dif.k = '0; dif.is_ac_level = 1'b0;
        dif.bit_valid = 1'b0; dif.bit_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_bit_ready", 32'(dif.bit_ready), 32'd0);
        chk("reset_output_valid", 32'(dif.output_valid), 32'd0);
        chk("reset_error", 32'(dif.error), 32'd0);
        chk("reset_val", dif.val, 32'd0);
        chk("reset_len", dif.codeword_length, 32'd0);
        chk("reset_is_minus", 32'(dif.is_minus), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // k=0 "1", started on the first cycle after reset release
        decode(0, 0, 64'b1, 1, 0, 0, 32'd0, 1'b0, 32'd1);
        // k=0 "011"
        decode(0, 0, 64'b011, 3, 0, 0, 32'd2, 1'b0, 32'd3);
        // k=2 "01001", then the same with bit_valid gaps
        decode(2, 0, 64'b01001, 5, 0, 0, 32'd5, 1'b0, 32'd5);
        decode(2, 0, 64'b01001, 5, 1, 0, 32'd5, 1'b0, 32'd5);
        // k=1 "11": sum 3 -> val 1
        decode(1, 0, 64'b11, 2, 0, 0, 32'd1, 1'b0, 32'd2);
        // k=3 "00101011": sum 43 -> val 35
        decode(3, 0, 64'b00101011, 8, 0, 0, 32'd35, 1'b0, 32'd8);
`ifdef EXP_GOLOMB_DEC_SIGN_EN
        decode(0, 1, 64'b0101, 4, 0, 0, 32'd1, 1'b1, 32'd4);
        decode(0, 1, 64'b10, 2, 1, 0, 32'd0, 1'b0, 32'd2);
`else
        decode(0, 1, 64'b010, 3, 0, 0, 32'd1, 1'b0, 32'd3);
        decode(0, 1, 64'b1, 1, 0, 0, 32'd0, 1'b0, 32'd1);
`endif
        // Largest legal prefix: 24 zeros, then sum = 1<<24 in 25 bits
        decode(0, 0, {15'd0, 24'd0, 1'b1, 24'd0}, 49, 0, 0, 32'd16777215, 1'b0, 32'd49);
        // 25 zeros overflow the prefix
        decode(0, 0, 64'd0, 25, 0, 1, 32'd0, 1'b0, 32'd0);
        // Results must hold after the error pulse
        chk("hold_val_after_error", dif.val, 32'd16777215);
        chk("hold_len_after_error", dif.codeword_length, 32'd49);

        // Abandon k=2 "01001" after two suffix bits
        dif.start = 1'b1; dif.k = 3'd2; dif.is_ac_level = 1'b0;
        @(posedge clk); #1;
        dif.start = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] pat;
            pat = 4'b0100;
            dif.bit_valid = 1'b1;
            dif.bit_in    = pat[i];
            @(posedge clk); #1;
        end
        dif.bit_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("ready_after_reset", 32'(dif.bit_ready), 32'd0);
        decode(0, 0, 64'b1, 1, 0, 0, 32'd0, 1'b0, 32'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
